// File: rtl/text_console_ctrl_if.sv
// text_console_ctrl_if: CPU I/O bus, direct CPU VRAM port and GPU character-RAM port of the console.
interface text_console_ctrl_if;
  logic [7:0]  din;
  logic [15:0] address;
  logic        w_en;
  logic        r_en;
  logic [7:0]  dout;
  logic        cpu_vram_we;
  logic [11:0] cpu_vram_addr;
  logic [7:0]  cpu_vram_din;
  logic        vram_we;
  logic [11:0] vram_addr;
  logic [7:0]  vram_din;
  logic [4:0]  scroll_row;
  logic        busy;
  modport master (
    output din, address, w_en, r_en, cpu_vram_we, cpu_vram_addr, cpu_vram_din,
    input  dout, vram_we, vram_addr, vram_din, scroll_row, busy
  );
  modport slave (
    input  din, address, w_en, r_en, cpu_vram_we, cpu_vram_addr, cpu_vram_din,
    output dout, vram_we, vram_addr, vram_din, scroll_row, busy
  );
endinterface

// File: rtl/text_console_ctrl.sv
// text_console_ctrl: turns DATA/CTRL register writes into character-RAM writes at a tracked cursor,
// scrolling by rotating scroll_row and yielding the VRAM port to direct CPU writes.
module text_console_ctrl #(
  parameter logic [7:0] CONSOLE_IO_ADDRESS = 8'h01,
  parameter int         COLS               = 80,
  parameter int         ROWS               = 30,
  parameter logic [7:0] FILL_CHAR          = 8'h20
) (
  input logic                clk,
  input logic                rst_n,
  text_console_ctrl_if.slave bus
);
  localparam logic [11:0] COLS_W = 12'(COLS);
  localparam logic [11:0] CELLS  = 12'(COLS * ROWS);
  typedef enum logic [1:0] {IDLE, PUT, FILL} state_e;
  state_e      state_q, state_d;
  logic [6:0]  col_q, col_d;
  logic [4:0]  row_q, row_d, scroll_q, scroll_d;
  logic        ovf_q, ovf_d, clr_q, clr_d;
  logic [7:0]  ch_q, ch_d, dout_q, dout_d;
  logic [11:0] fill_base_q, fill_base_d, fill_cnt_q, fill_cnt_d;
  logic [7:0]  io_off;
  logic [5:0]  prow_sum;
  logic [4:0]  prow;
  logic [11:0] put_addr;
  logic        data_wr, ctrl_wr, eng_go, busy, adv, fill_last;

  assign io_off    = bus.address[7:0] - CONSOLE_IO_ADDRESS;
  assign data_wr   = bus.w_en && io_off == 8'd0;
  assign ctrl_wr   = bus.w_en && io_off == 8'd1;
  assign busy      = state_q != IDLE;
  assign eng_go    = !bus.cpu_vram_we;
  assign prow_sum  = {1'b0, row_q} + {1'b0, scroll_q};
  assign prow      = prow_sum >= 6'(ROWS) ? 5'(prow_sum - 6'(ROWS)) : prow_sum[4:0];
  assign put_addr  = 12'(prow) * COLS_W + 12'(col_q);
  assign fill_last = fill_cnt_q == (clr_q ? CELLS : COLS_W) - 12'd1;

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    scroll_d    = scroll_q;
    ovf_d       = ovf_q;
    clr_d       = clr_q;
    ch_d        = ch_q;
    fill_base_d = fill_base_q;
    fill_cnt_d  = fill_cnt_q;
    adv         = 1'b0;
    if (state_q == IDLE && data_wr) begin
      if (bus.din >= 8'h20 && bus.din <= 8'h7E) begin
        state_d = PUT;
        ch_d    = bus.din;
      end else if (bus.din == 8'h0A) begin
        col_d = 7'd0;
        adv   = 1'b1;
      end else if (bus.din == 8'h0D) begin
        col_d = 7'd0;
      end else if (bus.din == 8'h08 && col_q != 7'd0) begin
        col_d = col_q - 7'd1;
      end
    end
    if (state_q == PUT && eng_go) begin
      state_d = IDLE;
      adv     = col_q == 7'(COLS - 1);
      col_d   = adv ? 7'd0 : col_q + 7'd1;
    end
    if (state_q == FILL && eng_go) begin
      fill_cnt_d = fill_last ? fill_cnt_q : fill_cnt_q + 12'd1;
      state_d    = fill_last ? IDLE : FILL;
      if (fill_last && clr_q) {col_d, row_d, scroll_d} = '0;
    end
    // after the rotation the new bottom physical row is the old top one, i.e. the old scroll_row
    if (adv) begin
      if (row_q < 5'(ROWS - 1)) row_d = row_q + 5'd1;
      else begin
        scroll_d    = scroll_q == 5'(ROWS - 1) ? 5'd0 : scroll_q + 5'd1;
        fill_base_d = 12'(scroll_q) * COLS_W;
        fill_cnt_d  = 12'd0;
        clr_d       = 1'b0;
        state_d     = FILL;
      end
    end
    if (data_wr && busy) ovf_d = 1'b1;
    if (ctrl_wr) begin
      if (bus.din[2]) ovf_d = 1'b0;
      if (bus.din[0]) begin
        state_d     = FILL;
        fill_base_d = 12'd0;
        fill_cnt_d  = 12'd0;
        clr_d       = 1'b1;
      end else if (bus.din[1] && !busy) begin
        {col_d, row_d} = '0;
      end
    end
  end

  assign dout_d = !bus.r_en    ? 8'h00 :
                  io_off == 8'd1 ? {5'b0, ovf_q, 1'b0, busy} :
                  io_off == 8'd2 ? {1'b0, col_q} :
                  io_off == 8'd3 ? {3'b0, row_q} : 8'h00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      col_q       <= '0;
      row_q       <= '0;
      scroll_q    <= '0;
      ovf_q       <= 1'b0;
      clr_q       <= 1'b0;
      ch_q        <= '0;
      fill_base_q <= '0;
      fill_cnt_q  <= '0;
      dout_q      <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      scroll_q    <= scroll_d;
      ovf_q       <= ovf_d;
      clr_q       <= clr_d;
      ch_q        <= ch_d;
      fill_base_q <= fill_base_d;
      fill_cnt_q  <= fill_cnt_d;
      dout_q      <= dout_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.busy       = busy;
  assign bus.scroll_row = scroll_q;
  assign bus.vram_we    = bus.cpu_vram_we || busy;
  assign bus.vram_addr  = bus.cpu_vram_we ? bus.cpu_vram_addr :
                          state_q == PUT ? put_addr :
                          state_q == FILL ? fill_base_q + fill_cnt_q : 12'd0;
  assign bus.vram_din   = bus.cpu_vram_we ? bus.cpu_vram_din :
                          state_q == PUT ? ch_q :
                          state_q == FILL ? FILL_CHAR : 8'h00;
endmodule

// File: tb/tb_text_console_ctrl.sv
// tb_text_console_ctrl: directed vector table, multi-cycle corner sequences and a randomized
// run compared against a screen-level console model.
module tb_text_console_ctrl;
  localparam logic [15:0] A_DATA = 16'h0001, A_CTRL = 16'h0002, A_COL = 16'h0003, A_ROW = 16'h0004;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  text_console_ctrl_if bus();
  text_console_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int eng_cnt = 0;
  logic [7:0] cap_mem [2400];
  typedef struct {logic [11:0] a; logic [7:0] d;} wr_t;
  wr_t eng_q[$];

  always @(negedge clk) if (rst_n && bus.vram_we) begin
    if (bus.vram_addr < 12'd2400) cap_mem[bus.vram_addr] = bus.vram_din;
    if (!bus.cpu_vram_we) begin
      eng_cnt++;
      eng_q.push_back('{bus.vram_addr, bus.vram_din});
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic io_write(logic [15:0] a, logic [7:0] d);
    bus.address = a;
    bus.din = d;
    bus.w_en = 1'b1;
    tick();
    bus.w_en = 1'b0;
  endtask

  task automatic io_read(logic [15:0] a, output logic [7:0] d);
    bus.address = a;
    bus.r_en = 1'b1;
    tick();
    bus.r_en = 1'b0;
    d = bus.dout;
  endtask

  task automatic wait_idle(int budget);
    int k = 0;
    while (bus.busy && k < budget) begin
      tick();
      k++;
    end
    check("idle_within_budget", bus.busy, 0);
  endtask

  task automatic check_cursor(string tag, int c, int r);
    logic [7:0] v;
    io_read(A_COL, v);
    check({tag, "_col"}, v, c);
    io_read(A_ROW, v);
    check({tag, "_row"}, v, r);
  endtask

  // screen-level model: logical cursor plus a rotating top-row offset
  int m_col, m_row, m_scr;
  logic [7:0] m_mem [2400];

  function automatic int m_advance();
    if (m_row < 29) begin
      m_row++;
      return 0;
    end
    m_scr = (m_scr + 1) % 30;
    for (int c = 0; c < 80; c++) m_mem[((29 + m_scr) % 30) * 80 + c] = 8'h20;
    return 80;
  endfunction

  function automatic int m_put(logic [7:0] ch);
    int w = 0;
    if (ch >= 8'h20 && ch <= 8'h7E) begin
      m_mem[((m_row + m_scr) % 30) * 80 + m_col] = ch;
      w = 1;
      if (m_col == 79) begin
        m_col = 0;
        w += m_advance();
      end else m_col++;
    end else if (ch == 8'h0A) begin
      m_col = 0;
      w = m_advance();
    end else if (ch == 8'h0D) m_col = 0;
    else if (ch == 8'h08 && m_col > 0) m_col--;
    return w;
  endfunction

  typedef struct {logic [7:0] ch; int col; int row; int writes;} vec_t;
  vec_t tbl[12];

  initial begin
    logic [7:0] v, ch;
    int mark, cnt0, bad, k, exp_w, r;
    tbl = '{'{8'h41, 1, 0, 1}, '{8'h42, 2, 0, 1}, '{8'h08, 1, 0, 0}, '{8'h0D, 0, 0, 0},
            '{8'h08, 0, 0, 0}, '{8'h0A, 0, 1, 0}, '{8'h07, 0, 1, 0}, '{8'h7E, 1, 1, 1},
            '{8'h7F, 1, 1, 0}, '{8'h1F, 1, 1, 0}, '{8'h20, 2, 1, 1}, '{8'h0A, 0, 2, 0}};
    bus.din = 0; bus.address = 0; bus.w_en = 0; bus.r_en = 0;
    bus.cpu_vram_we = 0; bus.cpu_vram_addr = 0; bus.cpu_vram_din = 0;
    repeat (3) tick();
    check("rst_vram_we", bus.vram_we, 0);
    check("rst_vram_addr", bus.vram_addr, 0);
    check("rst_vram_din", bus.vram_din, 0);
    check("rst_dout", bus.dout, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_scroll", bus.scroll_row, 0);
    rst_n = 1'b1;
    tick();
    // first char, then a DATA write sampled in the PUT cycle (busy falling) is dropped
    io_write(A_DATA, 8'h41);
    check("a_we", bus.vram_we, 1);
    check("a_addr", bus.vram_addr, 0);
    check("a_din", bus.vram_din, 8'h41);
    check("a_busy", bus.busy, 1);
    io_write(A_DATA, 8'h45);
    check("a_after_we", bus.vram_we, 0);
    check("a_after_busy", bus.busy, 0);
    check_cursor("a", 1, 0);
    io_read(A_CTRL, v);
    check("a_ovf_set", v, 8'h04);
    io_write(A_CTRL, 8'h04);
    io_read(A_CTRL, v);
    check("a_ovf_clr", v, 8'h00);
    io_write(A_DATA, 8'h0D);
    for (int i = 0; i < 12; i++) begin
      cnt0 = eng_cnt;
      mark = eng_q.size();
      io_write(A_DATA, tbl[i].ch);
      wait_idle(10);
      check($sformatf("tbl%0d_writes", i), eng_cnt - cnt0, tbl[i].writes);
      if (tbl[i].writes == 1 && eng_q.size() > mark) check($sformatf("tbl%0d_din", i), eng_q[mark].d, tbl[i].ch);
      check_cursor($sformatf("tbl%0d", i), tbl[i].col, tbl[i].row);
    end
    // a full row of 'B' starting at row 2 wraps to row 3
    mark = eng_q.size();
    for (int i = 0; i < 80; i++) begin
      io_write(A_DATA, 8'h42);
      wait_idle(10);
    end
    check("b_count", eng_q.size() - mark, 80);
    bad = 0;
    for (int i = 0; i < 80 && mark + i < eng_q.size(); i++)
      if (eng_q[mark + i].a != 12'(160 + i) || eng_q[mark + i].d != 8'h42) bad++;
    check("b_seq_bad", bad, 0);
    check_cursor("b", 0, 3);
    // clear with a 5-cycle CPU takeover in the middle
    mark = eng_q.size();
    io_write(A_CTRL, 8'h01);
    check("clr_busy", bus.busy, 1);
    repeat (1000) tick();
    bus.cpu_vram_addr = 12'hABC;
    bus.cpu_vram_din = 8'h5A;
    bus.cpu_vram_we = 1'b1;
    cnt0 = eng_cnt;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_we", bus.vram_we, 1);
      check("stall_addr", bus.vram_addr, 12'hABC);
      check("stall_din", bus.vram_din, 8'h5A);
      @(posedge clk);
      #1;
    end
    bus.cpu_vram_we = 1'b0;
    check("stall_engine_held", eng_cnt - cnt0, 0);
    wait_idle(3000);
    check("clr_count", eng_q.size() - mark, 2400);
    bad = 0;
    for (int i = 0; i < 2400 && mark + i < eng_q.size(); i++)
      if (eng_q[mark + i].a != 12'(i) || eng_q[mark + i].d != 8'h20) bad++;
    check("clr_seq_bad", bad, 0);
    check_cursor("clr", 0, 0);
    check("clr_scroll", bus.scroll_row, 0);
    // newline on the bottom row rotates the screen and blanks the new bottom row
    for (int i = 0; i < 29; i++) io_write(A_DATA, 8'h0A);
    check_cursor("pre_scroll", 0, 29);
    mark = eng_q.size();
    io_write(A_DATA, 8'h0A);
    check("scroll_first_fill", bus.scroll_row, 1);
    k = 0;
    while (bus.busy && k < 200) begin
      k++;
      tick();
    end
    check("scroll_busy_cycles", k, 80);
    check("scroll_count", eng_q.size() - mark, 80);
    bad = 0;
    for (int i = 0; i < 80 && mark + i < eng_q.size(); i++)
      if (eng_q[mark + i].a != 12'(i) || eng_q[mark + i].d != 8'h20) bad++;
    check("scroll_seq_bad", bad, 0);
    check_cursor("post_scroll", 0, 29);
    io_write(A_DATA, 8'h43);
    check("c_we", bus.vram_we, 1);
    check("c_addr", bus.vram_addr, 0);
    check("c_din", bus.vram_din, 8'h43);
    wait_idle(10);
    // DATA during a scroll fill is dropped and flagged
    mark = eng_q.size();
    io_write(A_DATA, 8'h0A);
    io_write(A_DATA, 8'h44);
    wait_idle(200);
    bad = 0;
    for (int i = mark; i < eng_q.size(); i++) if (eng_q[i].d == 8'h44) bad++;
    check("ovf_no_44", bad, 0);
    check("ovf_writes", eng_q.size() - mark, 80);
    io_read(A_CTRL, v);
    check("ovf_set", v, 8'h04);
    io_write(A_CTRL, 8'h04);
    io_read(A_CTRL, v);
    check("ovf_clr", v, 8'h00);
    check_cursor("ovf", 0, 29);
    check("ovf_scroll", bus.scroll_row, 2);
    // asynchronous reset in the middle of a clear
    io_write(A_CTRL, 8'h01);
    repeat (100) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_we", bus.vram_we, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_scroll", bus.scroll_row, 0);
    check("mid_rst_addr", bus.vram_addr, 0);
    check("mid_rst_dout", bus.dout, 0);
    cnt0 = eng_cnt;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (10) tick();
    check("mid_rst_no_writes", eng_cnt - cnt0, 0);
    check_cursor("mid_rst", 0, 0);
    io_read(A_CTRL, v);
    check("mid_rst_ctrl", v, 8'h00);
    // randomized traffic against the model
    io_write(A_CTRL, 8'h01);
    wait_idle(3000);
    m_col = 0;
    m_row = 0;
    m_scr = 0;
    for (int i = 0; i < 2400; i++) m_mem[i] = 8'h20;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      cnt0 = eng_cnt;
      if (r < 3) begin
        io_write(A_CTRL, 8'h02);
        m_col = 0;
        m_row = 0;
        exp_w = 0;
      end else begin
        ch = r < 20 ? 8'h0A : r < 25 ? 8'h0D : r < 30 ? 8'h08 :
             r < 36 ? 8'($urandom_range(0, 255)) : 8'($urandom_range(32, 126));
        io_write(A_DATA, ch);
        exp_w = m_put(ch);
        if ($urandom_range(0, 3) == 0) begin
          bus.cpu_vram_addr = 12'(2400 + $urandom_range(0, 1695));
          bus.cpu_vram_din = 8'($urandom_range(0, 255));
          bus.cpu_vram_we = 1'b1;
          repeat ($urandom_range(1, 3)) tick();
          bus.cpu_vram_we = 1'b0;
        end
      end
      wait_idle(300);
      check("rand_writes", eng_cnt - cnt0, exp_w);
      check("rand_scroll", bus.scroll_row, m_scr);
      check_cursor("rand", m_col, m_row);
    end
    bad = 0;
    for (int i = 0; i < 2400; i++) if (cap_mem[i] !== m_mem[i]) bad++;
    check("rand_image_bad_cells", bad, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/text_console_ctrl.md
# text_console_ctrl

Hardware text-console sequencer for the GPU character RAM. It turns CPU byte writes to one I/O register into VRAM writes at a hardware-tracked cursor, handling newline, carriage return, backspace, wrap and scroll. For scrolling it rotates a display row offset (`scroll_row`) instead of copying rows. It also runs clear-screen and blank-line fills, and shares the single VRAM write port between direct CPU VRAM writes and the engine, with the CPU always taking priority.

## Interface
Parameters:
- `CONSOLE_IO_ADDRESS`, 8'h01 — base I/O address; DATA=+0, CTRL=+1, COL=+2, ROW=+3
- `COLS`, 80 — characters per row
- `ROWS`, 30 — rows per screen
- `FILL_CHAR`, 8'h20 — byte written by clear and scroll fills

Ports:
- `clk` in 1 — CPU clock, the only clock
- `rst_n` in 1 — asynchronous active-low reset
- `din` in 8 — CPU write data
- `address` in 16 — CPU address; bits [7:0] decoded for I/O
- `w_en` in 1 — I/O write strobe
- `r_en` in 1 — I/O read strobe
- `dout` out 8 — registered read data; 0 when not addressed
- `cpu_vram_we` in 1 — direct CPU VRAM write request
- `cpu_vram_addr` in 12 — direct CPU VRAM address
- `cpu_vram_din` in 8 — direct CPU VRAM data
- `vram_we` out 1 — to GPU character RAM write enable
- `vram_addr` out 12 — to GPU character RAM write address
- `vram_din` out 8 — to GPU character RAM write data
- `scroll_row` out 5 — physical row displayed as logical row 0 (0..ROWS-1)
- `busy` out 1 — engine is not IDLE

## Operation
- **Cursor:** logical `col` (0..79) and `row` (0..29).
  - Physical row `prow = row + scroll_row`, minus 30 if the sum is ≥30.
  - Address `= prow*80 + col`, 12-bit, always <2400.
- **States:** IDLE, PUT, FILL.
- **DATA write while IDLE**, by byte value:
  - 0x20..0x7E: PUT writes the byte at the cursor, then `col+1`. If `col` was 79: `col=0` and advance row.
  - 0x0A: `col=0`, advance row; no VRAM write.
  - 0x0D: `col=0`.
  - 0x08: `col-1` if `col>0`, else unchanged.
  - Any other byte: ignored.
- **Advance row:**
  - If `row<29`: `row+1`.
  - Else: `scroll_row` increments (29→0), `row` stays 29, and FILL writes `FILL_CHAR` to all 80 cells of the new bottom physical row.
- **DATA write while busy:** dropped, and the sticky `ovf` bit is set.
- **CTRL write:**
  - bit0 = clear: from any state, aborts the current operation and enters FILL over cells 0..2399. On completion: `col=row=scroll_row=0`.
  - bit1 = home: `col=row=0`; honoured only when IDLE.
  - bit2 = 1 clears `ovf`.
  - If bit0 and bit1 are both set, clear wins.
- **Reads** (registered next cycle, same rules as other I/O blocks):
  - CTRL = {5'b0, `ovf`, 1'b0, `busy`}
  - COL = `col`
  - ROW = `row`
  - DATA reads 0.
- **Arbitration:**
  - If `cpu_vram_we` is high, `vram_we/addr/din` equal the CPU inputs that cycle, and the engine holds its pending write and counters.
  - Engine writes occur only in cycles with `cpu_vram_we` low.
- **Fill counter:** 12-bit start address plus count; it never exceeds the end cell, and no write goes beyond 2399.
- **Reset:** `col=row=scroll_row=0`, IDLE, `vram_we=0`, `vram_addr=0`, `vram_din=0`, `dout=0`, `busy=0`, `ovf=0`.
- **Reset mid-FILL:** abandons the fill immediately; no further writes.

## Timing
- DATA write sampled at edge N → engine VRAM write driven in cycle N+1 (combinational outputs from registered state), unless the CPU owns the port. Each CPU-owned cycle delays the write by one cycle.
- `busy` rises at N+1 and falls the cycle after the final engine write. Cursor registers update with that final write.
- Printable char: 1 write cycle. If it triggers a scroll: 1 + 80 write cycles; `scroll_row` updates at the first FILL cycle.
- Clear: 2400 write cycles (plus CPU stalls).
- 0x0A, 0x0D, 0x08 with no scroll: cursor updates at N+1, `busy` stays 0.
- Read data is valid the cycle after `r_en`.
- A DATA write in the same cycle `busy` falls is still dropped; the accept decision uses the registered state at edge N.

## Test plan
- Reset, write 0x41 to DATA → one `vram_we` pulse, `vram_addr=0`, `vram_din=0x41`; COL reads 1.
- Write 80 × 0x42 → addresses 0..79 written; COL=0, ROW=1.
- With ROW=29, write 0x0A → `scroll_row=1`; 80 writes of 0x20 at addresses 0..79; `busy` high for 80 cycles; ROW stays 29. Then 0x43 → `vram_addr=0`.
- CTRL=0x01 → 2400 writes of 0x20 at addresses 0..2399. Holding `cpu_vram_we` high for 5 cycles mid-fill → CPU data appears on the port, the fill pauses, and total engine writes remain 2400.
- While busy, write DATA 0x44 → no write of 0x44; CTRL reads bit2=1. Write CTRL=0x04 → bit2=0.
- Assert `rst_n` low mid-clear → `vram_we` goes 0 immediately; all registers return to reset values.
